multicycle_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/multicycle_ctrl_if.sv | 46 ++++
 rtl/mc_ctrl_decode.sv | 82 ++++++++
 rtl/multicycle_ctrl.sv | 130 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: opcodes,
// state encodings, datapath select encodings and the control-word record.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds bne dispatch).
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  // DECODE dispatch: where an opcode goes after decode; FETCH means illegal.
  function automatic state_e decode_dispatch(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE: nxt = S_EXECUTE;
      OP_LW:    nxt = S_MEMADR;
      OP_SW:    nxt = S_MEMADR;
      OP_BEQ:   nxt = S_BRANCH;
      OP_ADDI:  nxt = S_ADDIEX;
      OP_J:     nxt = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:   nxt = S_BRANCH;
`endif
      default:  nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multicycle control FSM.
// The master side is the controller; the slave side is the datapath.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds branch_ne).
interface multicycle_ctrl_if #(parameter int STATE_W = 4);

  logic [5:0]         opcode;
  logic               mem_ready;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               pc_write;
  logic               branch;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;
`ifdef MULTICYCLE_CTRL_BNE_EN
  logic               branch_ne;
`endif

  modport master (
    input  opcode, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch,
    output illegal_op, state_o
`ifdef MULTICYCLE_CTRL_BNE_EN
    , output branch_ne
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch,
    input  illegal_op, state_o
`ifdef MULTICYCLE_CTRL_BNE_EN
    , input branch_ne
`endif
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure state -> control-word decoder. FETCH raises ir_write/pc_write
// unconditionally here; the top gates them with the memory handshake.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // Map each state to its datapath enables and selects; anything unlisted is 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; control words come from mc_ctrl_decode. Memory
// states stall on mem_ready. All outputs are forced low while rst_n is low.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne -> BRANCH, branch_ne).
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int          STATE_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_e state_r;
  state_e state_nxt_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;
  logic   ready_s;
  logic   illegal_s;

  // With the handshake disabled every memory access completes at once.
  assign ready_s = (USE_MEM_READY != 32'd0) ? bus.mem_ready : 1'b1;

  // Illegal opcodes are only meaningful while the instruction is decoded.
  assign illegal_s = (state_r == S_DECODE) &&
                     (decode_dispatch(bus.opcode) == S_FETCH);

  mc_ctrl_decode u_decode (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state sequencing, including handshake stalls in memory states.
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (ready_s) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE:  state_nxt_s = decode_dispatch(bus.opcode);
      S_MEMADR: begin
        case (bus.opcode)
          OP_LW:   state_nxt_s = S_MEMRD;
          OP_SW:   state_nxt_s = S_MEMWR;
          default: state_nxt_s = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        if (ready_s) begin
          state_nxt_s = S_MEMWB;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMWB:   state_nxt_s = S_FETCH;
      S_MEMWR: begin
        if (ready_s) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_EXECUTE: state_nxt_s = S_ALUWB;
      S_ALUWB:   state_nxt_s = S_FETCH;
      S_BRANCH:  state_nxt_s = S_FETCH;
      S_ADDIEX:  state_nxt_s = S_ADDIWB;
      S_ADDIWB:  state_nxt_s = S_FETCH;
      S_JUMP:    state_nxt_s = S_FETCH;
      default:   state_nxt_s = S_FETCH;
    endcase
  end

  // FETCH loads IR and PC only in the cycle the instruction memory answers.
  always_comb begin
    ctrl_out_s = ctrl_s;
    if (state_r == S_FETCH) begin
      ctrl_out_s.ir_write = ctrl_s.ir_write & ready_s;
      ctrl_out_s.pc_write = ctrl_s.pc_write & ready_s;
    end else begin
      ctrl_out_s.ir_write = ctrl_s.ir_write;
      ctrl_out_s.pc_write = ctrl_s.pc_write;
    end
  end

  assign bus.iord       = rst_n & ctrl_out_s.iord;
  assign bus.mem_write  = rst_n & ctrl_out_s.mem_write;
  assign bus.ir_write   = rst_n & ctrl_out_s.ir_write;
  assign bus.reg_dst    = rst_n & ctrl_out_s.reg_dst;
  assign bus.mem_to_reg = rst_n & ctrl_out_s.mem_to_reg;
  assign bus.reg_write  = rst_n & ctrl_out_s.reg_write;
  assign bus.alu_src_a  = rst_n & ctrl_out_s.alu_src_a;
  assign bus.alu_src_b  = rst_n ? ctrl_out_s.alu_src_b : 2'b00;
  assign bus.alu_op     = rst_n ? ctrl_out_s.alu_op    : 2'b00;
  assign bus.pc_src     = rst_n ? ctrl_out_s.pc_src    : 2'b00;
  assign bus.pc_write   = rst_n & ctrl_out_s.pc_write;
  assign bus.branch     = rst_n & ctrl_out_s.branch;
  assign bus.illegal_op = rst_n & illegal_s;
  assign bus.state_o    = rst_n ? STATE_W'(state_r) : {STATE_W{1'b0}};

`ifdef MULTICYCLE_CTRL_BNE_EN
  logic bne_r;

  // Remember that the branch being executed is a bne, for the whole BRANCH state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bne_r <= 1'b0;
    end else begin
      bne_r <= (state_r == S_DECODE) && (bus.opcode == OP_BNE);
    end
  end

  assign bus.branch_ne = rst_n & bne_r & (state_r == S_BRANCH);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Expected behaviour comes from a
// per-instruction trace model: each instruction expands into the list of
// phases it visits (with stall cycles) and each phase has its control row.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

  multicycle_ctrl #(.USE_MEM_READY(1), .STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } cyc_t;

  cyc_t trace_q[$];

  function automatic bit known_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010) ||
           (BNE_EN && (op == 6'b000101));
  endfunction

  // Expected output vector for one cycle spent in phase st.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic [5:0] op);
    logic iord = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0, m2r = 1'b0, rw = 1'b0;
    logic sa = 1'b0, pw = 1'b0, br = 1'b0, ill = 1'b0, bne = 1'b0;
    logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  begin sb = 2'b11; ill = !known_op(op); end
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1;
                   bne = BNE_EN && (op == 6'b000101); end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pw = 1'b1; end
      default: iord = 1'b0;
    endcase
    return {st, iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pw, br, ill, bne};
  endfunction

  function automatic logic [20:0] obs_vec();
    logic bne;
`ifdef MULTICYCLE_CTRL_BNE_EN
    bne = bus.branch_ne;
`else
    bne = 1'b0;
`endif
    return {bus.state_o, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.pc_write, bus.branch, bus.illegal_op, bne};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    trace_q.push_back({st, rdy});
  endtask

  // Expand one instruction into its phase sequence: fetch stalls fs, memory stalls ms.
  task automatic build_trace(input logic [5:0] op, input int fs, input int ms);
    trace_q.delete();
    repeat (fs) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(0, 1)));
    if (op == 6'b000000) begin
      push(4'd6, 1'($urandom_range(0, 1)));
      push(4'd7, 1'($urandom_range(0, 1)));
    end else if (op == 6'b100011) begin
      push(4'd2, 1'($urandom_range(0, 1)));
      repeat (ms) push(4'd3, 1'b0);
      push(4'd3, 1'b1);
      push(4'd4, 1'($urandom_range(0, 1)));
    end else if (op == 6'b101011) begin
      push(4'd2, 1'($urandom_range(0, 1)));
      repeat (ms) push(4'd5, 1'b0);
      push(4'd5, 1'b1);
    end else if (op == 6'b000100 || (BNE_EN && op == 6'b000101)) begin
      push(4'd8, 1'($urandom_range(0, 1)));
    end else if (op == 6'b001000) begin
      push(4'd9, 1'($urandom_range(0, 1)));
      push(4'd10, 1'($urandom_range(0, 1)));
    end else if (op == 6'b000010) begin
      push(4'd11, 1'($urandom_range(0, 1)));
    end else begin
      // illegal: DECODE falls straight back to FETCH
    end
  endtask

  task automatic test_reset();
    logic [20:0] o;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'($urandom);
    #2;
    o = obs_vec();
    total++;
    if (o !== 21'd0) begin bad++; $display("FAIL reset_async got=%h exp=%h", o, 21'd0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== 21'd0) begin bad++; $display("FAIL reset_held got=%h exp=%h", o, 21'd0); end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd0, 1'b0, 6'd0)) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", o, exp_vec(4'd0, 1'b0, 6'd0));
    end
    @(posedge clk);
  endtask

  task automatic test_directed();
    logic [5:0] ops [10] = '{6'b100011, 6'b000000, 6'b101011, 6'b000000, 6'b111111,
                             6'b000101, 6'b000100, 6'b001000, 6'b000010, 6'b100011};
    int fss [10] = '{0, 0, 0, 2, 0, 0, 0, 1, 0, 1};
    int mss [10] = '{0, 0, 3, 0, 0, 0, 0, 0, 0, 2};
    logic [20:0] o, e;
    for (int k = 0; k < 10; k++) begin
      build_trace(ops[k], fss[k], mss[k]);
      for (int i = 0; i < trace_q.size(); i++) begin
        #1;
        bus.mem_ready = trace_q[i].rdy;
        bus.opcode = (trace_q[i].st == 4'd1 || trace_q[i].st == 4'd2) ? ops[k] : 6'($urandom);
        @(negedge clk);
        e = exp_vec(trace_q[i].st, trace_q[i].rdy, ops[k]);
        o = obs_vec();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL directed op=%b cyc=%0d got=%h exp=%h", ops[k], i, o, e);
        end
        @(posedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_execute();
    logic [20:0] o;
    #1; bus.mem_ready = 1'b1; bus.opcode = 6'($urandom);
    @(posedge clk);
    #1; bus.opcode = 6'b000000;
    @(posedge clk);
    #1; bus.mem_ready = 1'b0; bus.opcode = 6'($urandom);
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd6, 1'b0, 6'd0)) begin
      bad++; $display("FAIL mid_exec_state got=%h exp=%h", o, exp_vec(4'd6, 1'b0, 6'd0));
    end
    #2; rst_n = 1'b0; bus.mem_ready = 1'b1;
    #1;
    o = obs_vec();
    total++;
    if (o !== 21'd0) begin bad++; $display("FAIL mid_exec_reset got=%h exp=%h", o, 21'd0); end
    @(posedge clk);
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== 21'd0) begin bad++; $display("FAIL mid_exec_hold got=%h exp=%h", o, 21'd0); end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1; bus.mem_ready = 1'b1;
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd0, 1'b1, 6'd0)) begin
      bad++; $display("FAIL resume_fetch got=%h exp=%h", o, exp_vec(4'd0, 1'b1, 6'd0));
    end
    @(posedge clk);
    #1; bus.opcode = 6'b000010;
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd1, 1'b1, 6'b000010)) begin
      bad++; $display("FAIL resume_decode got=%h exp=%h", o, exp_vec(4'd1, 1'b1, 6'b000010));
    end
    @(posedge clk);
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd11, 1'b1, 6'b000010)) begin
      bad++; $display("FAIL resume_jump got=%h exp=%h", o, exp_vec(4'd11, 1'b1, 6'b000010));
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] pool [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b001000, 6'b000010, 6'b000101, 6'b111111};
    logic [5:0] op;
    logic [20:0] o, e;
    int sel;
    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom_range(0, 8));
      op = (sel == 8) ? 6'($urandom) : pool[sel];
      build_trace(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      for (int i = 0; i < trace_q.size(); i++) begin
        #1;
        bus.mem_ready = trace_q[i].rdy;
        bus.opcode = (trace_q[i].st == 4'd1 || trace_q[i].st == 4'd2) ? op : 6'($urandom);
        @(negedge clk);
        e = exp_vec(trace_q[i].st, trace_q[i].rdy, op);
        o = obs_vec();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL b2b k=%0d op=%b cyc=%0d got=%h exp=%h", k, op, i, o, e);
        end
        @(posedge clk);
      end
    end
    #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    o = obs_vec();
    total++;
    if (o !== exp_vec(4'd0, 1'b0, 6'd0)) begin
      bad++; $display("FAIL b2b_final got=%h exp=%h", o, exp_vec(4'd0, 1'b0, 6'd0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_execute();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
